// File: rtl/io_responder_pkg.sv
// Shared op encoding and command-word field positions for the IO command responder.
// Register 15 is the read-only window onto the accepted-command counter.
package io_responder_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_WRITE = 3'd1,
        OP_READ  = 3'd2,
        OP_SWAP  = 3'd3,
        OP_COUNT = 3'd4,
        OP_RSV5  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    localparam int OP_LSB    = 24;
    localparam int OP_MSB    = 26;
    localparam int ADDR_LSB  = 16;
    localparam int ADDR_MSB  = 19;
    localparam int WDATA_LSB = 0;
    localparam int CNT_W     = 16;

    localparam logic [3:0] RO_REG = 4'd15;

endpackage

// File: rtl/io_response_queue.sv
// Synchronous response FIFO: push/pop at the clock edge, head entry read straight from storage flops
// so it appears one cycle after push; no full bypass, caller must not push while full.
module io_response_queue #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic             full,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;

    assign valid     = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign head_data = mem[head];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= push_data;
    end

endmodule

// File: rtl/io_command_responder.sv
// Decodes controller commands against a 16-entry register file and queues responses (latency 1).
// Commands are refused while the response queue is full; responses hold until IOResponseREQ.
module io_command_responder #(
    parameter int PORTBYTEWIDTH = 4,
    parameter int DATABITWIDTH  = 16,
    parameter int QUEUEDEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic                       clk_en,
    input  logic                       IOCommandEn,
    input  logic                       IOResponseRequested,
    input  logic [3:0]                 IODestRegOut,
    input  logic [PORTBYTEWIDTH*8-1:0] IODataOut,
    input  logic                       IOResponseREQ,
    output logic                       IOACK,
    output logic                       IOCommandResponse,
    output logic                       IORegResponseFlag,
    output logic                       IOMemResponseFlag,
    output logic [3:0]                 IODestRegIn,
    output logic [PORTBYTEWIDTH*8-1:0] IODataIn
);
    import io_responder_pkg::*;

    localparam int PW = PORTBYTEWIDTH * 8;
    localparam int QW = 1 + 4 + PW;

    logic [DATABITWIDTH-1:0] regs [16];
    logic [CNT_W-1:0]        cmd_cnt;
    logic [CNT_W-1:0]        cnt_next;

    op_e                     op;
    logic [3:0]              addr;
    logic [DATABITWIDTH-1:0] wdata;
    logic                    unused_cmd;

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    need_rsp;
    logic                    reg_wr;
    logic [PW-1:0]           rd_val;
    logic [PW-1:0]           rsp_data;

    logic                    q_valid;
    logic                    q_full;
    logic [QW-1:0]           q_head;
    logic                    show;

    assign op         = op_e'(IODataOut[OP_MSB:OP_LSB]);
    assign addr       = IODataOut[ADDR_MSB:ADDR_LSB];
    assign wdata      = IODataOut[WDATA_LSB +: DATABITWIDTH];
    assign unused_cmd = ^IODataOut;

    assign IOCommandResponse = clk_en && !sync_rst && !q_full;
    assign accept            = IOCommandEn && IOCommandResponse;
    assign pop               = q_valid && IOResponseREQ && clk_en && !sync_rst;
    assign cnt_next          = cmd_cnt + CNT_W'(1);

    // Counter reads report the value including the command being accepted.
    always_comb begin
        rd_val   = '0;
        rsp_data = '0;
        need_rsp = IOResponseRequested;
        reg_wr   = 1'b0;
        if (addr == RO_REG)
            rd_val[CNT_W-1:0] = cnt_next;
        else
            rd_val[DATABITWIDTH-1:0] = regs[addr];
        case (op)
            OP_WRITE: reg_wr = (addr != RO_REG);
            OP_READ: begin
                rsp_data = rd_val;
                need_rsp = 1'b1;
            end
            OP_SWAP: begin
                rsp_data = rd_val;
                need_rsp = 1'b1;
                reg_wr   = (addr != RO_REG);
            end
            OP_COUNT: begin
                rsp_data[CNT_W-1:0] = cnt_next;
                need_rsp = 1'b1;
            end
            default: ;
        endcase
    end

    assign push = accept && need_rsp;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
            cmd_cnt <= '0;
        end else if (accept) begin
            cmd_cnt <= cnt_next;
            if (reg_wr)
                regs[addr] <= wdata;
        end
    end

    io_response_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUEDEPTH)
    ) u_queue (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .push      (push),
        .push_data ({IOResponseRequested, IODestRegOut, rsp_data}),
        .pop       (pop),
        .valid     (q_valid),
        .full      (q_full),
        .head_data (q_head)
    );

    assign show              = q_valid && !sync_rst;
    assign IORegResponseFlag = show && q_head[QW-1];
    assign IOMemResponseFlag = show && !q_head[QW-1];
    assign IODestRegIn       = show ? q_head[QW-2 -: 4] : 4'd0;
    assign IODataIn          = show ? q_head[PW-1:0] : '0;
    assign IOACK             = accept || (q_valid && clk_en && !sync_rst);

endmodule

// File: doc/io_command_responder.md
IO_COMMAND_RESPONDER -- requirements
Module: io_command_responder

Interface
REQ-001 Parameter PORTBYTEWIDTH, default 4, SHALL set command/response word width (PORTBYTEWIDTH*8); legal values >=4.
REQ-002 Parameter DATABITWIDTH, default 16, SHALL set the width of each of the 16 local registers.
REQ-003 Parameter QUEUEDEPTH, default 4, SHALL set response-queue entries; power of two, >=2.
REQ-004 clk  in  1  single clock; the block SHALL use one clock and a synchronous, active-high reset.
REQ-005 sync_rst  in  1  synchronous active-high reset.
REQ-006 clk_en  in  1  global enable; no state change and no handshake completion while 0.
REQ-007 IOCommandEn  in  1  command valid from the controller.
REQ-008 IOResponseRequested  in  1  controller requests a register writeback for this command.
REQ-009 IODestRegOut  in  4  destination register tag carried with the command.
REQ-010 IODataOut  in  PORTBYTEWIDTH*8  command word.
REQ-011 IOResponseREQ  in  1  controller response path ready.
REQ-012 IOACK  out  1  responder active (command accept or response valid).
REQ-013 IOCommandResponse  out  1  responder can accept a command this cycle.
REQ-014 IORegResponseFlag  out  1  head response is a register writeback.
REQ-015 IOMemResponseFlag  out  1  head response updates load buffer only.
REQ-016 IODestRegIn  out  4  tag of head response.
REQ-017 IODataIn  out  PORTBYTEWIDTH*8  data of head response.

Function
REQ-018 Command fields SHALL be: op = IODataOut[26:24], addr = IODataOut[19:16], wdata = IODataOut[DATABITWIDTH-1:0]; other bits ignored.
REQ-019 Ops SHALL be: 0 NOP, 1 WRITE, 2 READ, 3 SWAP (return old value, write new), 4 COUNT (return accepted-command counter), 5-7 treated as NOP.
REQ-020 IOCommandResponse SHALL equal clk_en && ~sync_rst && (queue count < QUEUEDEPTH); no same-cycle full bypass.
REQ-021 A command SHALL be accepted on the cycle where IOCommandEn && IOCommandResponse.
REQ-022 IOACK SHALL equal (IOCommandEn && IOCommandResponse) || (RespValid && clk_en && ~sync_rst).
REQ-023 WRITE/SWAP SHALL update reg[addr] at the accepting edge; a READ accepted the next cycle returns the new value.
REQ-024 Register 15 SHALL be read-only; writes to it are dropped, reads return the 16-bit accepted-command counter (wraps 0xFFFF->0).
REQ-025 Counter SHALL increment on every accepted command, all ops including NOP.
REQ-026 READ, SWAP, COUNT SHALL always enqueue one response; WRITE and NOP SHALL enqueue one only if IOResponseRequested=1.
REQ-027 Response flag SHALL be Reg if IOResponseRequested=1, else Mem; tag = IODestRegOut; data = value zero-extended to port width (WRITE/NOP data = 0).
REQ-028 Enqueue SHALL occur at the accepting edge; response visible on outputs the following cycle (latency 1).
REQ-029 Response SHALL dequeue on RespValid && IOResponseREQ && clk_en; flags and IOACK held stable until then.
REQ-030 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order.
REQ-031 When queue empty, both flags SHALL be 0 and IODestRegIn/IODataIn SHALL be 0.

Reset
REQ-032 On sync_rst: all 15 writable registers 0, counter 0, queue empty, pointers 0.
REQ-033 While sync_rst=1: IOACK, IOCommandResponse, both flags 0; IODestRegIn, IODataIn 0; in-flight command dropped, queued responses discarded.
REQ-034 Reset SHALL take priority over clk_en.

Structure
REQ-035 Package io_responder_pkg SHALL hold the op enum, field LSB/MSB constants and the read-only register index (15).
REQ-036 Sub-module io_response_queue SHALL implement the synchronous FIFO (count, head/tail wrap, registered head outputs).
REQ-037 Register file and decode SHALL live in io_command_responder.

Verification
REQ-038 WRITE addr3 0xBEEF, no request; then READ addr3 requested tag 5 -> single Reg response, tag 5, data 0x0000BEEF.
REQ-039 SWAP addr2 0x1234 after WRITE addr2 0x00AA -> response data 0x00AA; subsequent READ -> 0x1234.
REQ-040 IOResponseREQ=0, 5 READs issued -> 4 accepted, IOCommandResponse=0 on 5th; release -> responses drain in order, 5th then accepted.
REQ-041 3 NOPs then COUNT, IOResponseRequested=0 -> Mem response, data 4; WRITE addr15 0xFFFF ignored.
REQ-042 sync_rst asserted with 2 queued responses and IOCommandEn=1 -> flags 0, IOACK 0 same cycle; after reset READ addr3 -> 0.
REQ-043 clk_en=0 with IOCommandEn=1, IOResponseREQ=1, response queued -> no accept, no dequeue, counter unchanged.
